// File: rtl/cmp_multi.sv
// Multi-channel minimum-energy tracker: per-cycle min across channels (stage 1),
// best-so-far update with stall/target termination (stage 2), IDLE/RUN/DONE control.
module cmp_multi #(
    parameter int ENERGY_W   = 15,
    parameter int NUM_SPIN   = 64,
    parameter int NUM_CH     = 4,
    parameter int FAIL_W     = 16,
    parameter int TIE_UPDATE = 0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic [NUM_CH-1:0]            cand_valid_i,
    input  logic [NUM_CH*ENERGY_W-1:0]   cand_energy_i,
    input  logic [NUM_CH*NUM_SPIN-1:0]   cand_spin_i,
    input  logic [FAIL_W-1:0]            max_fails_i,
    input  logic                         target_en_i,
    input  logic [ENERGY_W-1:0]          target_energy_i,
    input  logic                         done_ack_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [1:0]                   done_cause_o,
    output logic                         best_valid_o,
    output logic [ENERGY_W-1:0]          best_energy_o,
    output logic [NUM_SPIN-1:0]          best_spin_o,
    output logic [CH_W-1:0]              best_ch_o,
    output logic [FAIL_W-1:0]            fail_count_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                      state_q;
    logic                        s1_valid_q;
    logic signed [ENERGY_W-1:0]  s1_energy_q;
    logic [NUM_SPIN-1:0]         s1_spin_q;
    logic [CH_W-1:0]             s1_ch_q;
    logic                        best_valid_q, best_valid_d;
    logic signed [ENERGY_W-1:0]  best_energy_q, best_energy_d;
    logic [NUM_SPIN-1:0]         best_spin_q, best_spin_d;
    logic [CH_W-1:0]             best_ch_q, best_ch_d;
    logic [FAIL_W-1:0]           fail_count_q, fail_count_d;
    logic [1:0]                  done_cause_q;

    logic                        min_hit;
    logic signed [ENERGY_W-1:0]  min_energy;
    logic [NUM_SPIN-1:0]         min_spin;
    logic [CH_W-1:0]             min_ch;
    logic                        improve, stall, target_hit, term;

    // Strict less-than keeps the lowest index on equal energies.
    always_comb begin
        min_hit    = 1'b0;
        min_energy = '0;
        min_spin   = '0;
        min_ch     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cand_valid_i[i] &&
                (!min_hit || $signed(cand_energy_i[i*ENERGY_W +: ENERGY_W]) < min_energy)) begin
                min_hit    = 1'b1;
                min_energy = $signed(cand_energy_i[i*ENERGY_W +: ENERGY_W]);
                min_spin   = cand_spin_i[i*NUM_SPIN +: NUM_SPIN];
                min_ch     = CH_W'(i);
            end
        end
    end

    always_comb begin
        improve = s1_valid_q &&
                  (!best_valid_q || (s1_energy_q < best_energy_q) ||
                   ((TIE_UPDATE != 0) && (s1_energy_q == best_energy_q)));
        best_valid_d  = best_valid_q | improve;
        best_energy_d = improve ? s1_energy_q : best_energy_q;
        best_spin_d   = improve ? s1_spin_q   : best_spin_q;
        best_ch_d     = improve ? s1_ch_q     : best_ch_q;
        if (improve) begin
            fail_count_d = '0;
        end else if (s1_valid_q && (fail_count_q != '1)) begin
            fail_count_d = fail_count_q + 1'b1;
        end else begin
            fail_count_d = fail_count_q;
        end
        stall      = s1_valid_q && (max_fails_i != '0) && (fail_count_d >= max_fails_i);
        target_hit = s1_valid_q && target_en_i && best_valid_d &&
                     (best_energy_d <= $signed(target_energy_i));
        term       = stall | target_hit;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            s1_valid_q    <= 1'b0;
            s1_energy_q   <= '0;
            s1_spin_q     <= '0;
            s1_ch_q       <= '0;
            best_valid_q  <= 1'b0;
            best_energy_q <= '0;
            best_spin_q   <= '0;
            best_ch_q     <= '0;
            fail_count_q  <= '0;
            done_cause_q  <= 2'b00;
        end else if (start_i) begin
            // Best energy/spin/ch deliberately keep their old values here.
            state_q      <= StRun;
            s1_valid_q   <= 1'b0;
            best_valid_q <= 1'b0;
            fail_count_q <= '0;
            done_cause_q <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: ;
                StRun: begin
                    best_valid_q  <= best_valid_d;
                    best_energy_q <= best_energy_d;
                    best_spin_q   <= best_spin_d;
                    best_ch_q     <= best_ch_d;
                    fail_count_q  <= fail_count_d;
                    // A result captured on the terminating edge is dropped.
                    s1_valid_q    <= min_hit && !term;
                    if (min_hit) begin
                        s1_energy_q <= min_energy;
                        s1_spin_q   <= min_spin;
                        s1_ch_q     <= min_ch;
                    end
                    if (term) begin
                        state_q      <= StDone;
                        done_cause_q <= {target_hit, stall};
                    end
                end
                StDone: begin
                    if (done_ack_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = (state_q == StRun);
    assign done_o        = (state_q == StDone);
    assign done_cause_o  = done_cause_q;
    assign best_valid_o  = best_valid_q;
    assign best_energy_o = best_energy_q;
    assign best_spin_o   = best_spin_q;
    assign best_ch_o     = best_ch_q;
    assign fail_count_o  = fail_count_q;

endmodule

// File: tb/tb_cmp_multi.sv
// Bench for cmp_multi: two instances (TIE_UPDATE 0 and 1) on shared stimulus,
// every cycle compared against a queue-free behavioural model of the tracker.
module tb_cmp_multi;

    localparam int EW = 15;
    localparam int NS = 64;
    localparam int NC = 4;
    localparam int FW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, ack, ten;
    logic [NC-1:0]  vld;
    int             en [NC];
    logic [NS-1:0]  sp [NC];
    logic [FW-1:0]  max_fails;
    int             tgt;
    logic [NC*EW-1:0] cand_energy;
    logic [NC*NS-1:0] cand_spin;
    logic [EW-1:0]    target_energy;

    always_comb begin
        cand_energy = '0;
        cand_spin   = '0;
        for (int i = 0; i < NC; i++) begin
            cand_energy[i*EW +: EW] = en[i][EW-1:0];
            cand_spin[i*NS +: NS]   = sp[i];
        end
    end
    assign target_energy = tgt[EW-1:0];

    logic          busy0, done0, bv0, busy1, done1, bv1;
    logic [1:0]    cause0, cause1, bc0, bc1;
    logic [EW-1:0] be0, be1;
    logic [NS-1:0] bs0, bs1;
    logic [FW-1:0] fc0, fc1;

    cmp_multi #(.ENERGY_W(EW), .NUM_SPIN(NS), .NUM_CH(NC), .FAIL_W(FW), .TIE_UPDATE(0)) u_dut0 (
        .clk_i(clk), .reset_i(rst), .start_i(start), .cand_valid_i(vld),
        .cand_energy_i(cand_energy), .cand_spin_i(cand_spin), .max_fails_i(max_fails),
        .target_en_i(ten), .target_energy_i(target_energy), .done_ack_i(ack),
        .busy_o(busy0), .done_o(done0), .done_cause_o(cause0), .best_valid_o(bv0),
        .best_energy_o(be0), .best_spin_o(bs0), .best_ch_o(bc0), .fail_count_o(fc0)
    );

    cmp_multi #(.ENERGY_W(EW), .NUM_SPIN(NS), .NUM_CH(NC), .FAIL_W(FW), .TIE_UPDATE(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst), .start_i(start), .cand_valid_i(vld),
        .cand_energy_i(cand_energy), .cand_spin_i(cand_spin), .max_fails_i(max_fails),
        .target_en_i(ten), .target_energy_i(target_energy), .done_ack_i(ack),
        .busy_o(busy1), .done_o(done1), .done_cause_o(cause1), .best_valid_o(bv1),
        .best_energy_o(be1), .best_spin_o(bs1), .best_ch_o(bc1), .fail_count_o(fc1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state per tie policy: 0 = idle, 1 = run, 2 = done.
    int            m_state [2] = '{0, 0};
    int            m_pv [2]    = '{0, 0};
    int            m_pe [2];
    logic [NS-1:0] m_ps [2];
    int            m_pc [2];
    int            m_bv [2]    = '{0, 0};
    int            m_be [2]    = '{0, 0};
    logic [NS-1:0] m_bs [2]    = '{64'd0, 64'd0};
    int            m_bc [2]    = '{0, 0};
    int            m_fail [2]  = '{0, 0};
    int            m_cause [2] = '{0, 0};

    task automatic model_step(input int k);
        int mn, mc, npv;
        bit any, imp, stl, hit;
        if (rst) begin
            m_state[k] = 0; m_pv[k] = 0; m_bv[k] = 0; m_be[k] = 0; m_bs[k] = '0;
            m_bc[k] = 0; m_fail[k] = 0; m_cause[k] = 0;
            return;
        end
        if (start) begin
            m_state[k] = 1; m_pv[k] = 0; m_bv[k] = 0; m_fail[k] = 0; m_cause[k] = 0;
            return;
        end
        npv = 0;
        mn  = 0;
        mc  = 0;
        if (m_state[k] == 1) begin
            any = 0;
            for (int i = 0; i < NC; i++)
                if (vld[i] && (!any || en[i] < mn)) begin mn = en[i]; any = 1; end
            if (any) begin
                npv = 1;
                for (int i = NC - 1; i >= 0; i--) if (vld[i] && en[i] == mn) mc = i;
            end
            if (m_pv[k] != 0) begin
                imp = (m_bv[k] == 0) || (m_pe[k] < m_be[k]) || (m_pe[k] == m_be[k] && k == 1);
                if (imp) begin
                    m_bv[k] = 1; m_be[k] = m_pe[k]; m_bs[k] = m_ps[k]; m_bc[k] = m_pc[k];
                    m_fail[k] = 0;
                end else if (m_fail[k] < 65535) begin
                    m_fail[k] = m_fail[k] + 1;
                end
                stl = (max_fails != 0) && (m_fail[k] >= int'(max_fails));
                hit = ten && (m_bv[k] != 0) && (m_be[k] <= tgt);
                if (stl || hit) begin
                    m_state[k] = 2;
                    m_cause[k] = (hit ? 2 : 0) + (stl ? 1 : 0);
                    npv = 0;
                end
            end
        end else if (m_state[k] == 2 && ack) begin
            m_state[k] = 0;
        end
        m_pv[k] = npv;
        if (npv != 0) begin m_pe[k] = mn; m_ps[k] = sp[mc]; m_pc[k] = mc; end
    endtask

    function automatic logic [101:0] expect_vec(input int k);
        return {m_state[k] == 1, m_state[k] == 2, 2'(m_cause[k]), m_bv[k] != 0,
                EW'(m_be[k]), m_bs[k], 2'(m_bc[k]), FW'(m_fail[k])};
    endfunction

    task automatic chk(input string tag, input logic [101:0] obs, input logic [101:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        chk({tag, "/tie0"}, {busy0, done0, cause0, bv0, be0, bs0, bc0, fc0}, expect_vec(0));
        chk({tag, "/tie1"}, {busy1, done1, cause1, bv1, be1, bs1, bc1, fc1}, expect_vec(1));
    endtask

    function automatic logic [101:0] e15(input int v);
        return 102'(v[EW-1:0]);
    endfunction

    task automatic idle_inputs();
        start = 0; ack = 0; vld = '0;
        for (int i = 0; i < NC; i++) begin en[i] = 0; sp[i] = {$urandom, $urandom}; end
    endtask

    task automatic one_cand(input int ch, input int e);
        vld = '0; vld[ch] = 1'b1; en[ch] = e; sp[ch] = {$urandom, $urandom};
    endtask

    initial begin
        rst = 1; max_fails = '0; ten = 0; tgt = 0;
        idle_inputs();
        cyc("reset"); cyc("reset");
        chk("reset_zero", {busy0, done0, cause0, bv0, be0, bs0, bc0, fc0}, '0);
        rst = 0;

        // Four-way min with a tie between ch1 and ch2.
        max_fails = 3; start = 1; cyc("r42_start"); start = 0;
        vld = 4'b1111; en[0] = 5; en[1] = -2; en[2] = -2; en[3] = 7;
        cyc("r42_cand"); idle_inputs(); cyc("r42_s1"); cyc("r42_s2");
        chk("r42_energy", 102'(be0), e15(-2));
        chk("r42_ch", 102'(bc0), 102'(1));
        chk("r42_fail", 102'(fc0), 102'(0));

        // Stall termination, then a late candidate must be ignored.
        start = 1; cyc("r43_start"); start = 0;
        foreach (en[i]) en[i] = 0;
        one_cand(0, 10); cyc("r43_c"); one_cand(0, 8); cyc("r43_c");
        one_cand(0, 9); cyc("r43_c"); cyc("r43_c"); cyc("r43_c");
        idle_inputs(); cyc("r43_f"); cyc("r43_f");
        chk("r43_done", {100'd0, done0, busy0}, 102'b10);
        chk("r43_cause", 102'(cause0), 102'b01);
        one_cand(3, -50); cyc("r43_late"); idle_inputs(); cyc("r43_late"); cyc("r43_late");
        chk("r43_energy", 102'(be0), e15(8));
        ack = 1; cyc("r43_ack"); ack = 0;

        // Equal energies on different channels: policy-dependent winner.
        max_fails = 0; start = 1; cyc("r44_start"); start = 0;
        one_cand(2, 4); cyc("r44_c"); one_cand(0, 4); cyc("r44_c");
        idle_inputs(); cyc("r44_f"); cyc("r44_f");
        chk("r44_ch_tie0", 102'(bc0), 102'(2));
        chk("r44_fail_tie0", 102'(fc0), 102'(1));
        chk("r44_ch_tie1", 102'(bc1), 102'(0));
        chk("r44_fail_tie1", 102'(fc1), 102'(0));

        // Target termination and acknowledge.
        ten = 1; tgt = -10; start = 1; cyc("r45_start"); start = 0;
        one_cand(1, -12); cyc("r45_c"); idle_inputs(); cyc("r45_f"); cyc("r45_f");
        chk("r45_cause", {99'd0, done0, cause0}, 102'b110);
        ack = 1; cyc("r45_ack"); ack = 0;
        chk("r45_idle", {100'd0, busy0, done0}, 102'b00);
        chk("r45_energy", 102'(be0), e15(-12));
        ten = 0;

        // Randomized traffic with occasional start, ack and reset.
        for (int seg = 0; seg < 10; seg++) begin
            max_fails = FW'($urandom_range(0, 6));
            ten = 1'($urandom_range(0, 1));
            tgt = $urandom_range(0, 300) - 250;
            start = 1; cyc("rnd_start"); start = 0;
            for (int n = 0; n < 40; n++) begin
                vld = NC'($urandom);
                for (int i = 0; i < NC; i++) begin
                    en[i] = $urandom_range(0, 400) - 200;
                    sp[i] = {$urandom, $urandom};
                end
                start = ($urandom_range(0, 39) == 0);
                ack   = ($urandom_range(0, 3) == 0);
                rst   = ($urandom_range(0, 99) == 0);
                cyc("rnd");
                rst = 0;
            end
            idle_inputs();
        end

        // Reset with a candidate in flight.
        ten = 0; max_fails = 0; start = 1; cyc("r47_start"); start = 0;
        one_cand(2, -7); cyc("r47_c"); idle_inputs();
        rst = 1; cyc("r47_rst"); rst = 0;
        cyc("r47_after"); cyc("r47_after"); cyc("r47_after");
        chk("r47_zero", {busy0, done0, cause0, bv0, be0, bs0, bc0, fc0}, '0);

        // Fail counter saturation with stall termination disabled.
        max_fails = 0; start = 1; cyc("r46_start"); start = 0;
        one_cand(0, -16384); cyc("r46_first");
        en[0] = 0;
        for (int n = 0; n < 70001; n++) cyc("r46_run");
        idle_inputs(); cyc("r46_f");
        chk("r46_sat", 102'(fc0), 102'(65535));
        chk("r46_nodone", {100'd0, busy0, done0}, 102'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmp_multi.md
CMP_MULTI -- requirements
Module: cmp_multi

Interface
REQ-001 SHALL have parameter ENERGY_W, default 15: signed energy width in bits.
REQ-002 SHALL have parameter NUM_SPIN, default 64: spin vector width.
REQ-003 SHALL have parameter NUM_CH, default 4 (range 1..16): number of candidate channels.
REQ-004 SHALL have parameter FAIL_W, default 16: width of the stall counter and of max_fails.
REQ-005 SHALL have parameter TIE_UPDATE, default 0: 0 keeps the incumbent on equal energy, 1 replaces it.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  clears results and arms a run.
REQ-010 cand_valid  in  NUM_CH  per-channel candidate valid.
REQ-011 cand_energy  in  NUM_CH*ENERGY_W  signed energies; channel i occupies slice i.
REQ-012 cand_spin  in  NUM_CH*NUM_SPIN  spin vectors; channel i occupies slice i.
REQ-013 max_fails  in  FAIL_W  stall limit; 0 disables stall termination.
REQ-014 target_en  in  1  enables early stop on target energy.
REQ-015 target_energy  in  ENERGY_W  signed target energy.
REQ-016 done_ack  in  1  acknowledges done.
REQ-017 busy  out  1  high while in state RUN.
REQ-018 done  out  1  high while in state DONE.
REQ-019 done_cause  out  2  bit0 = stall limit reached, bit1 = target reached.
REQ-020 best_valid  out  1  high once any result has been captured this run.
REQ-021 best_energy  out  ENERGY_W  signed best energy.
REQ-022 best_spin  out  NUM_SPIN  spin vector of the best result.
REQ-023 best_ch  out  max(1,$clog2(NUM_CH))  source channel of the best result.
REQ-024 fail_count  out  FAIL_W  consecutive non-improving evaluations.

Function
REQ-025 FSM SHALL have three states: IDLE, RUN, DONE. Reset enters IDLE.
REQ-026 start in any state SHALL, at the next edge:
- enter RUN;
- clear best_valid, fail_count, done_cause and the stage-1 register;
- hold best_energy, best_spin and best_ch at their old values, which are don't-care while best_valid=0.
REQ-027 Stage 1 (edge t+1, RUN only) SHALL register the minimum-energy valid channel, using a signed compare; equal energies resolve to the lowest channel index. Cycles with no valid channel SHALL register nothing.
REQ-028 Candidates SHALL be ignored in IDLE and DONE, and in the cycle start is asserted.
REQ-029 Stage 2 (edge t+2) SHALL count an evaluation as an improvement when any of these holds:
- best_valid=0;
- winner < best_energy;
- winner == best_energy and TIE_UPDATE=1.
REQ-030 On an improvement, stage 2 SHALL load best_energy/spin/ch, set best_valid=1 and clear fail_count to 0.
REQ-031 On a non-improving evaluation, stage 2 SHALL increment fail_count by 1 and saturate it at all-ones; there SHALL be one increment per evaluation, not one per channel.
REQ-032 Termination SHALL be evaluated on post-update values at the same edge t+2:
- stall = (max_fails!=0 && fail_count_next >= max_fails);
- target = (target_en && best_valid_next && best_energy_next <= target_energy).
REQ-033 If either termination condition holds, the FSM SHALL enter DONE and latch done_cause = {target, stall}; both bits may be set together.
REQ-034 A stage-1 result pending when DONE is entered SHALL be discarded.
REQ-035 Latency: a candidate sampled at edge t SHALL be visible on best_* outputs after edge t+2, and done SHALL rise after the same edge t+2.
REQ-036 done_ack sampled high in DONE SHALL move the FSM to IDLE at the next edge; done_ack SHALL be ignored in IDLE and RUN.
REQ-037 best_* outputs, fail_count and done_cause SHALL hold through DONE and IDLE until the next start.
REQ-038 start and done_ack high together in DONE: start SHALL win.

Reset
REQ-039 reset SHALL override start and every other input.
REQ-040 On reset, state SHALL be IDLE and all outputs SHALL be 0, including best_energy, best_spin and best_ch.
REQ-041 Reset asserted mid-RUN SHALL abort the run and clear the pipeline with no done pulse.

Verification
REQ-042 NUM_CH=4, max_fails=3; start; one cycle of ch0..3 = {5,-2,-2,7} -> 2 cycles later best_energy=-2, best_ch=1, fail_count=0.
REQ-043 Energies 10, 8, 9, 9, 9 one per cycle, max_fails=3 -> best_energy=8; done rises with done_cause=01 after the third non-improving evaluation; a later candidate of -50 is ignored.
REQ-044 TIE_UPDATE=0 vs 1; candidates E=4 on ch2 then E=4 on ch0 -> best_ch=2 with fail_count=1, or best_ch=0 with fail_count=0, respectively.
REQ-045 target_en=1, target_energy=-10; candidate -12 -> done with done_cause=10; done_ack -> IDLE next edge; best_energy stays -12.
REQ-046 max_fails=0, 70000 non-improving evaluations with FAIL_W=16 -> fail_count saturates at 65535 and done never rises.
REQ-047 Reset pulsed while RUN has a candidate in flight -> after reset all outputs are 0 and no best update or done occurs.
